// File: rtl/risc8_pkg.sv
// Shared types and default widths for the risc8 data-memory path.
package risc8_pkg;

    localparam int unsigned RISC8_ADDR_W = 8;
    localparam int unsigned RISC8_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCoreRd,
        StHostRd
    } arb_state_t;

endpackage

// File: rtl/risc8_dmem_arbiter.sv
// Data-memory arbiter: the MEM stage has priority over the host/debug port, and a bounded
// wait counter forces a starving host request through.
module risc8_dmem_arbiter
    import risc8_pkg::*;
#(
    parameter int unsigned ADDR_W        = RISC8_ADDR_W,
    parameter int unsigned DATA_W        = RISC8_DATA_W,
    parameter int unsigned HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CNT_W    = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(HOST_MAX_WAIT);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;

    logic w_idle;
    logic w_force_host;
    logic w_grant_host;
    logic w_grant_core;

    assign w_idle       = (r_state == StIdle);
    assign w_force_host = (r_wait_cnt == WAIT_MAX);
    assign w_grant_host = w_idle && host_valid && (w_force_host || !core_req);
    assign w_grant_core = w_idle && core_req && !w_grant_host;

    assign host_rvalid = r_host_rvalid;
    assign host_rdata  = r_host_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_wait_cnt    <= '0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            r_host_rvalid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_grant_host) begin
                        r_wait_cnt <= '0;
                        if (!host_we) begin
                            r_state <= StHostRd;
                        end
                    end else if (w_grant_core) begin
                        // Only a waiting host ages; saturate at the force threshold.
                        if (host_valid && !w_force_host) begin
                            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        end
                        if (!core_we) begin
                            r_state <= StCoreRd;
                        end
                    end
                end
                StCoreRd: begin
                    r_state <= StIdle;
                end
                StHostRd: begin
                    r_host_rdata  <= mem_rdata;
                    r_host_rvalid <= 1'b1;
                    r_state       <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Decoded from state and request inputs only; mem_rdata never reaches core_stall.
    always_comb begin
        core_stall = core_req;
        core_rdata = '0;
        host_ready = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (reset_n) begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_host) begin
                        host_ready = 1'b1;
                        mem_en     = 1'b1;
                        mem_we     = host_we;
                        mem_addr   = host_addr;
                        mem_wdata  = host_wdata;
                    end else if (w_grant_core) begin
                        mem_en     = 1'b1;
                        mem_we     = core_we;
                        mem_addr   = core_addr;
                        mem_wdata  = core_wdata;
                        core_stall = !core_we;
                    end
                end
                StCoreRd: begin
                    core_rdata = mem_rdata;
                    core_stall = 1'b0;
                end
                StHostRd: begin
                    core_stall = core_req;
                end
                default: begin
                    core_stall = core_req;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc8_dmem_arbiter.sv
// Self-checking bench for risc8_dmem_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_risc8_dmem_arbiter;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          core_req = 1'b0;
    logic          core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          host_valid = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ready;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    risc8_dmem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .HOST_MAX_WAIT(MAXW)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .host_valid (host_valid),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ready (host_ready),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous single-port memory behind the arbiter.
    logic [DW-1:0] tb_mem [256];
    logic          preload = 1'b1;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] a;
        a = 8'(i);
        if (a == 8'h10) return 8'h5A;
        if (a == 8'h05) return 8'hC3;
        return a ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic       creq, cwe;
        logic [7:0] caddr, cwd;
        logic       hv, hwe;
        logic [7:0] haddr, hwd;
        logic       e0_stall, e0_ready, e0_en, e0_we;
        logic [7:0] e0_addr, e0_wd;
        logic       e1_stall, e1_en;
        logic [7:0] e1_rdata;
    } vec_t;

    vec_t vecs [7];

    // Reference model state
    logic [7:0] m_mem [256];
    int         m_phase, nxt_phase, m_wait;
    logic [7:0] m_cap, m_hrd;
    logic       m_rv, host_wins, core_wins, host_pending;
    logic       exp_stall, exp_ready, exp_en, exp_we, exp_rv;
    logic [7:0] exp_addr, exp_wd, exp_crd, exp_hrd;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                    1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 8'h21, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00,
                    1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 8'h11, 1'b0, 1'b1, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00,
                    1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h5A};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00,
                    1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h06, 8'h44,
                    1'b0, 1'b1, 1'b1, 1'b1, 8'h06, 8'h44, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00,
                    1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h5A};
        vecs[6] = '{1'b1, 1'b1, 8'h22, 8'h12, 1'b1, 1'b1, 8'h07, 8'h55,
                    1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 8'h12, 1'b0, 1'b1, 8'h00};

        // Reset values, with core_stall following core_req
        #1;
        core_req = 1'b1;
        #1;
        check("rst_stall_req1", core_stall, 1);
        check("rst_mem_en", mem_en, 0);
        check("rst_host_ready", host_ready, 0);
        check("rst_core_rdata", core_rdata, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_host_rdata", host_rdata, 0);
        core_req = 1'b0;
        #1;
        check("rst_stall_req0", core_stall, 0);
        tick();
        tick();
        preload = 1'b0;
        reset_n = 1'b1;

        // Directed vectors, each from a fresh reset
        for (int v = 0; v < 7; v++) begin
            tick();
            pulse_reset();
            core_req = vecs[v].creq; core_we = vecs[v].cwe;
            core_addr = vecs[v].caddr; core_wdata = vecs[v].cwd;
            host_valid = vecs[v].hv; host_we = vecs[v].hwe;
            host_addr = vecs[v].haddr; host_wdata = vecs[v].hwd;
            #1;
            check($sformatf("v%0d_c0_stall", v), core_stall, vecs[v].e0_stall);
            check($sformatf("v%0d_c0_ready", v), host_ready, vecs[v].e0_ready);
            check($sformatf("v%0d_c0_en", v), mem_en, vecs[v].e0_en);
            check($sformatf("v%0d_c0_we", v), mem_we, vecs[v].e0_we);
            check($sformatf("v%0d_c0_addr", v), mem_addr, vecs[v].e0_addr);
            check($sformatf("v%0d_c0_wdata", v), mem_wdata, vecs[v].e0_wd);
            tick();
            host_valid = 1'b0;
            #1;
            check($sformatf("v%0d_c1_stall", v), core_stall, vecs[v].e1_stall);
            check($sformatf("v%0d_c1_en", v), mem_en, vecs[v].e1_en);
            check($sformatf("v%0d_c1_rdata", v), core_rdata, vecs[v].e1_rdata);
            clear_inputs();
        end

        // Core read of 0x10, then core write/read-back of 0x20
        tick();
        pulse_reset();
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
        #1;
        check("crd_stall0", core_stall, 1);
        tick();
        check("crd_stall1", core_stall, 0);
        check("crd_data", core_rdata, 8'h5A);
        tick();
        core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h33;
        #1;
        check("cwr_mem_we", mem_we, 1);
        check("cwr_stall", core_stall, 0);
        tick();
        core_we = 1'b0; core_wdata = 8'h00;
        #1;
        check("crb_stall0", core_stall, 1);
        tick();
        check("crb_data", core_rdata, 8'h33);
        check("crb_stall1", core_stall, 0);
        tick();
        clear_inputs();

        // Host read of 0x05 with the core idle
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h05;
        #1;
        check("hrd_ready", host_ready, 1);
        tick();
        host_valid = 1'b0;
        #1;
        check("hrd_rvalid_c1", host_rvalid, 0);
        tick();
        check("hrd_rvalid_c2", host_rvalid, 1);
        check("hrd_rdata_c2", host_rdata, 8'hC3);
        tick();
        check("hrd_rvalid_c3", host_rvalid, 0);
        check("hrd_rdata_hold", host_rdata, 8'hC3);

        // Starvation: continuous core writes vs a held host write
        host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h77;
        core_req = 1'b1; core_we = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            core_addr = 8'(8'h80 + k); core_wdata = 8'(k);
            #1;
            if (k < 5) begin
                check($sformatf("starve_ready_%0d", k), host_ready, 0);
                check($sformatf("starve_stall_%0d", k), core_stall, 0);
                check($sformatf("starve_addr_%0d", k), mem_addr, 8'h80 + k);
            end else begin
                check("forced_ready", host_ready, 1);
                check("forced_stall", core_stall, 1);
                check("forced_addr", mem_addr, 8'h40);
                check("forced_wdata", mem_wdata, 8'h77);
            end
            tick();
        end
        host_valid = 1'b0; core_addr = 8'h86;
        #1;
        check("after_force_ready", host_ready, 0);
        check("after_force_stall", core_stall, 0);
        check("after_force_addr", mem_addr, 8'h86);
        tick();
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h41;
        #1;
        check("cnt_cleared_ready", host_ready, 0);
        tick();
        host_valid = 1'b0; core_we = 1'b0; core_addr = 8'h40;
        #1;
        check("rd40_stall", core_stall, 1);
        tick();
        check("rd40_data", core_rdata, 8'h77);
        tick();
        clear_inputs();

        // Reset during HOST_RD drops the pending read
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h05;
        #1;
        check("rsthr_ready", host_ready, 1);
        tick();
        host_valid = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h90; core_wdata = 8'h01;
        #1;
        check("rsthr_stall_in_rd", core_stall, 1);
        check("rsthr_en_in_rd", mem_en, 0);
        reset_n = 1'b0;
        #1;
        check("rsthr_stall_rst", core_stall, 1);
        check("rsthr_en_rst", mem_en, 0);
        check("rsthr_rvalid_rst", host_rvalid, 0);
        reset_n = 1'b1;
        #1;
        check("rsthr_idle_en", mem_en, 1);
        check("rsthr_idle_stall", core_stall, 0);
        tick();
        clear_inputs();
        #1;
        check("rsthr_rvalid_a", host_rvalid, 0);
        tick();
        check("rsthr_rvalid_b", host_rvalid, 0);
        check("rsthr_rdata", host_rdata, 0);

        // Randomized run against the reference model
        tick();
        pulse_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = tb_mem[i];
        m_phase = 0; m_wait = 0; m_rv = 1'b0; m_hrd = 8'h00; m_cap = 8'h00;
        host_pending = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) tick();
            if (!host_pending) begin
                host_valid = ($urandom_range(0, 2) == 0);
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = 8'($urandom_range(0, 15));
                host_wdata = 8'($urandom);
            end
            core_req   = ($urandom_range(0, 9) < 8);
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = 8'($urandom_range(0, 15));
            core_wdata = 8'($urandom);
            #1;

            exp_rv = m_rv; exp_hrd = m_hrd;
            exp_stall = core_req; exp_ready = 1'b0; exp_en = 1'b0; exp_we = 1'b0;
            exp_addr = 8'h00; exp_wd = 8'h00; exp_crd = 8'h00;
            nxt_phase = 0;
            if (m_phase == 0) begin
                host_wins = host_valid && (m_wait >= MAXW || !core_req);
                core_wins = core_req && !host_wins;
                if (host_wins) begin
                    exp_ready = 1'b1; exp_en = 1'b1; exp_we = host_we;
                    exp_addr = host_addr; exp_wd = host_wdata;
                    m_wait = 0;
                    if (host_we) m_mem[host_addr] = host_wdata;
                    else begin nxt_phase = 2; m_cap = m_mem[host_addr]; end
                end else if (core_wins) begin
                    exp_en = 1'b1; exp_we = core_we;
                    exp_addr = core_addr; exp_wd = core_wdata;
                    exp_stall = !core_we;
                    if (host_valid && m_wait < MAXW) m_wait++;
                    if (core_we) m_mem[core_addr] = core_wdata;
                    else begin nxt_phase = 1; m_cap = m_mem[core_addr]; end
                end
            end else if (m_phase == 1) begin
                exp_stall = 1'b0;
                exp_crd = m_cap;
            end

            check("rnd_stall", core_stall, exp_stall);
            check("rnd_ready", host_ready, exp_ready);
            check("rnd_mem_en", mem_en, exp_en);
            check("rnd_mem_we", mem_we, exp_we);
            check("rnd_mem_addr", mem_addr, exp_addr);
            check("rnd_mem_wdata", mem_wdata, exp_wd);
            check("rnd_core_rdata", core_rdata, exp_crd);
            check("rnd_host_rvalid", host_rvalid, exp_rv);
            check("rnd_host_rdata", host_rdata, exp_hrd);

            m_rv = (m_phase == 2);
            if (m_phase == 2) m_hrd = m_cap;
            m_phase = nxt_phase;
            host_pending = host_valid && !exp_ready;
        end
        clear_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
